// File: rtl/mem_access_stage_if.sv
// SRAM-like data port between the memory stage and the data memory.
// The stage is the master; the memory side answers with addr_ok / data_ok.
interface mem_access_stage_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-stage data-access unit: issues loads/stores on the data port,
// aligns/extends load data and registers the writeback record.
module mem_access_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_addr,
  input  logic        in_read,
  input  logic        in_write,
  input  logic [2:0]  in_lw_sw_type,
  input  logic [3:0]  in_byte_enable,
  input  logic [31:0] in_store_val,
  input  logic [31:0] in_alu_val,
  input  logic        in_wren,
  input  logic [4:0]  in_wt_addr,
  input  logic        flush,
  mem_access_stage_if.master dbus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic        out_wren,
  output logic [4:0]  out_wt_addr,
  output logic [31:0] out_wt_val,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  localparam logic [2:0] T_LB  = 3'd0;
  localparam logic [2:0] T_LBU = 3'd1;
  localparam logic [2:0] T_LH  = 3'd2;
  localparam logic [2:0] T_LHU = 3'd3;
  localparam logic [2:0] T_SB  = 3'd5;
  localparam logic [2:0] T_SH  = 3'd6;

  state_t      state, state_next;
  logic [31:0] pc_q;
  logic [2:0]  type_q;
  logic        wren_q;
  logic [4:0]  wt_addr_q;

  logic        accept, accept_mem, accept_alu, mem_done;
  logic [1:0]  size_sel;
  logic [31:0] wdata_sel;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign in_ready   = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept     = in_valid && in_ready;
  assign accept_mem = accept && (in_read || in_write);
  assign accept_alu = accept && !(in_read || in_write);
  assign mem_done   = (state == WAIT) && dbus.data_data_ok && !flush;

  always_comb begin
    state_next = state;
    dbus.data_req = 1'b0;
    busy = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept_mem) state_next = REQ;
      end
      REQ: begin
        dbus.data_req = 1'b1;
        // A flush racing an accepted address still owes us a response.
        if (dbus.data_addr_ok) state_next = flush ? DISCARD : WAIT;
        else if (flush)        state_next = IDLE;
      end
      WAIT: begin
        if (dbus.data_data_ok) state_next = IDLE;
        else if (flush)        state_next = DISCARD;
      end
      DISCARD: begin
        if (dbus.data_data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    size_sel  = 2'd2;
    wdata_sel = in_store_val;
    case (in_lw_sw_type)
      T_LB, T_LBU, T_SB: size_sel = 2'd0;
      T_LH, T_LHU, T_SH: size_sel = 2'd1;
      default:           size_sel = 2'd2;
    endcase
    if (in_lw_sw_type == T_SB)      wdata_sel = {4{in_store_val[7:0]}};
    else if (in_lw_sw_type == T_SH) wdata_sel = {2{in_store_val[15:0]}};
  end

  // Request fields stay frozen from accept until the next accepted request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dbus.data_wr    <= 1'b0;
      dbus.data_size  <= 2'd0;
      dbus.data_addr  <= 32'd0;
      dbus.data_wstrb <= 4'd0;
      dbus.data_wdata <= 32'd0;
      pc_q            <= 32'd0;
      type_q          <= 3'd0;
      wren_q          <= 1'b0;
      wt_addr_q       <= 5'd0;
    end else if (accept_mem) begin
      dbus.data_wr    <= in_write;
      dbus.data_size  <= size_sel;
      dbus.data_addr  <= in_addr;
      dbus.data_wstrb <= in_write ? in_byte_enable : 4'd0;
      dbus.data_wdata <= wdata_sel;
      pc_q            <= in_pc;
      type_q          <= in_lw_sw_type;
      wren_q          <= in_wren;
      wt_addr_q       <= in_wt_addr;
    end
  end

  always_comb begin
    shifted  = dbus.data_rdata >> {dbus.data_addr[1:0], 3'b000};
    load_val = shifted;
    case (type_q)
      T_LB:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      T_LBU:   load_val = {24'd0, shifted[7:0]};
      T_LH:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      T_LHU:   load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
    if (dbus.data_wr) load_val = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid   <= 1'b0;
      out_pc      <= 32'd0;
      out_wren    <= 1'b0;
      out_wt_addr <= 5'd0;
      out_wt_val  <= 32'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_alu) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_wren    <= in_wren;
      out_wt_addr <= in_wt_addr;
      out_wt_val  <= in_alu_val;
    end else if (mem_done) begin
      out_valid   <= 1'b1;
      out_pc      <= pc_q;
      out_wren    <= dbus.data_wr ? 1'b0 : wren_q;
      out_wt_addr <= wt_addr_q;
      out_wt_val  <= load_val;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, loads, stores,
// flushes, backpressure and reset in flight.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_addr;
  logic        in_read, in_write;
  logic [2:0]  in_lw_sw_type;
  logic [3:0]  in_byte_enable;
  logic [31:0] in_store_val, in_alu_val;
  logic        in_wren;
  logic [4:0]  in_wt_addr;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic        out_wren;
  logic [4:0]  out_wt_addr;
  logic [31:0] out_wt_val;
  logic        busy;
  int          total = 0;
  int          bad = 0;

  mem_access_stage_if dbus ();

  mem_access_stage dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_addr(in_addr),
    .in_read(in_read), .in_write(in_write), .in_lw_sw_type(in_lw_sw_type),
    .in_byte_enable(in_byte_enable), .in_store_val(in_store_val),
    .in_alu_val(in_alu_val), .in_wren(in_wren), .in_wt_addr(in_wt_addr),
    .flush(flush), .dbus(dbus),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_wren(out_wren), .out_wt_addr(out_wt_addr), .out_wt_val(out_wt_val),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single edge, then withdraws it.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] addr,
                               input logic rd, input logic wr, input logic [2:0] typ,
                               input logic [3:0] be, input logic [31:0] sv,
                               input logic [31:0] alu, input logic wren,
                               input logic [4:0] wt);
    in_pc = pc; in_addr = addr; in_read = rd; in_write = wr;
    in_lw_sw_type = typ; in_byte_enable = be; in_store_val = sv;
    in_alu_val = alu; in_wren = wren; in_wt_addr = wt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic memTxn(input int addrWait, input int dataWait, input logic [31:0] rdata);
    for (int i = 0; i < addrWait; i++) tick();
    dbus.data_addr_ok = 1'b1;
    tick();
    dbus.data_addr_ok = 1'b0;
    for (int i = 0; i < dataWait; i++) tick();
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata = rdata;
    tick();
    dbus.data_data_ok = 1'b0;
  endtask

  task automatic loadCase(input string tag, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    applyStimulus(32'h0000_0100, addr, 1'b1, 1'b0, typ, 4'b0000, 32'd0,
                  32'hCAFE_0000, 1'b1, 5'd9);
    memTxn(1, 2, rdata);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_val"}, out_wt_val, exp);
    tick();
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = 0; in_addr = 0; in_read = 0; in_write = 0; in_lw_sw_type = 0;
    in_byte_enable = 0; in_store_val = 0; in_alu_val = 0; in_wren = 0; in_wt_addr = 0;
    dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b0; dbus.data_rdata = 32'd0;
    tick(); tick();
    checkOutput("rst_req", {31'd0, dbus.data_req}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_outvalid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_addr", dbus.data_addr, 32'd0);
    checkOutput("rst_wtval", out_wt_val, 32'd0);
    resetn = 1'b1;
    tick();
    checkOutput("idle_inready", {31'd0, in_ready}, 32'd1);

    $display("[TB] ALU pass-through");
    applyStimulus(32'h0000_0040, 32'd0, 1'b0, 1'b0, 3'd4, 4'd0, 32'd0,
                  32'h1234_5678, 1'b1, 5'd5);
    checkOutput("alu_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("alu_val", out_wt_val, 32'h1234_5678);
    checkOutput("alu_wt", {27'd0, out_wt_addr}, 32'd5);
    checkOutput("alu_wren", {31'd0, out_wren}, 32'd1);
    checkOutput("alu_pc", out_pc, 32'h0000_0040);
    checkOutput("alu_noreq", {31'd0, dbus.data_req}, 32'd0);
    tick();
    checkOutput("alu_drain", {31'd0, out_valid}, 32'd0);

    $display("[TB] LB request fields");
    applyStimulus(32'h0000_0080, 32'h0000_1003, 1'b1, 1'b0, 3'd0, 4'b1000, 32'd0,
                  32'd0, 1'b1, 5'd7);
    checkOutput("lb_req", {31'd0, dbus.data_req}, 32'd1);
    checkOutput("lb_wr", {31'd0, dbus.data_wr}, 32'd0);
    checkOutput("lb_size", {30'd0, dbus.data_size}, 32'd0);
    checkOutput("lb_addr", dbus.data_addr, 32'h0000_1003);
    checkOutput("lb_wstrb", {28'd0, dbus.data_wstrb}, 32'd0);
    memTxn(1, 2, 32'h80FF_0000);
    checkOutput("lb_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("lb_val", out_wt_val, 32'hFFFF_FF80);
    checkOutput("lb_pc", out_pc, 32'h0000_0080);
    checkOutput("lb_wt", {27'd0, out_wt_addr}, 32'd7);
    tick();

    loadCase("lbu", 3'd1, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
    loadCase("lh", 3'd2, 32'h0000_2002, 32'h8001_7777, 32'hFFFF_8001);
    loadCase("lhu", 3'd3, 32'h0000_2000, 32'h1234_F00D, 32'h0000_F00D);
    loadCase("lb1", 3'd0, 32'h0000_2001, 32'h0000_7F00, 32'h0000_007F);
    loadCase("lw", 3'd4, 32'h0000_2000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    $display("[TB] Stores");
    applyStimulus(32'h0000_00C0, 32'h0000_3002, 1'b0, 1'b1, 3'd6, 4'b1100,
                  32'h0000_ABCD, 32'd0, 1'b0, 5'd0);
    checkOutput("sh_wr", {31'd0, dbus.data_wr}, 32'd1);
    checkOutput("sh_size", {30'd0, dbus.data_size}, 32'd1);
    checkOutput("sh_wdata", dbus.data_wdata, 32'hABCD_ABCD);
    checkOutput("sh_wstrb", {28'd0, dbus.data_wstrb}, 32'hC);
    memTxn(0, 0, 32'h5555_5555);
    checkOutput("sh_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("sh_wren", {31'd0, out_wren}, 32'd0);
    checkOutput("sh_val", out_wt_val, 32'd0);
    tick();
    applyStimulus(32'h0000_00C4, 32'h0000_3001, 1'b0, 1'b1, 3'd5, 4'b0010,
                  32'h1234_565A, 32'd0, 1'b1, 5'd3);
    checkOutput("sb_wdata", dbus.data_wdata, 32'h5A5A_5A5A);
    checkOutput("sb_size", {30'd0, dbus.data_size}, 32'd0);
    checkOutput("sb_wstrb", {28'd0, dbus.data_wstrb}, 32'h2);
    memTxn(0, 0, 32'd0);
    checkOutput("sb_wren", {31'd0, out_wren}, 32'd0);
    tick();
    applyStimulus(32'h0000_00C8, 32'h0000_3004, 1'b0, 1'b1, 3'd7, 4'b1111,
                  32'h0BAD_F00D, 32'd0, 1'b0, 5'd0);
    checkOutput("sw_wdata", dbus.data_wdata, 32'h0BAD_F00D);
    checkOutput("sw_size", {30'd0, dbus.data_size}, 32'd2);
    memTxn(0, 0, 32'd0);
    tick();

    $display("[TB] Flush in REQ");
    applyStimulus(32'h0000_0200, 32'h0000_4000, 1'b1, 1'b0, 3'd4, 4'd0, 32'd0,
                  32'd0, 1'b1, 5'd4);
    flush = 1'b1;
    #1;
    checkOutput("fl_inready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    checkOutput("flreq_req", {31'd0, dbus.data_req}, 32'd0);
    checkOutput("flreq_busy", {31'd0, busy}, 32'd0);
    checkOutput("flreq_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] Flush in WAIT");
    applyStimulus(32'h0000_0204, 32'h0000_4004, 1'b1, 1'b0, 3'd4, 4'd0, 32'd0,
                  32'd0, 1'b1, 5'd4);
    dbus.data_addr_ok = 1'b1;
    tick();
    dbus.data_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flw_busy", {31'd0, busy}, 32'd1);
    checkOutput("flw_req", {31'd0, dbus.data_req}, 32'd0);
    checkOutput("flw_inready", {31'd0, in_ready}, 32'd0);
    tick();
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata = 32'h1111_2222;
    tick();
    dbus.data_data_ok = 1'b0;
    checkOutput("flw_novalid", {31'd0, out_valid}, 32'd0);
    checkOutput("flw_idle", {31'd0, busy}, 32'd0);
    checkOutput("flw_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] Backpressure");
    out_ready = 1'b0;
    applyStimulus(32'h0000_0300, 32'd0, 1'b0, 1'b0, 3'd4, 4'd0, 32'd0,
                  32'hA5A5_0001, 1'b1, 5'd12);
    checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("bp_inready", {31'd0, in_ready}, 32'd0);
    in_alu_val = 32'h9999_9999;
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("bp_hold_val", out_wt_val, 32'hA5A5_0001);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release", {31'd0, out_valid}, 32'd0);

    $display("[TB] Reset during WAIT");
    applyStimulus(32'h0000_0400, 32'h0000_5008, 1'b1, 1'b0, 3'd4, 4'd0, 32'd0,
                  32'd0, 1'b1, 5'd6);
    dbus.data_addr_ok = 1'b1;
    tick();
    dbus.data_addr_ok = 1'b0;
    checkOutput("rw_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checkOutput("rw_idle", {31'd0, busy}, 32'd0);
    checkOutput("rw_addr", dbus.data_addr, 32'd0);
    checkOutput("rw_req", {31'd0, dbus.data_req}, 32'd0);
    dbus.data_data_ok = 1'b1;
    dbus.data_rdata = 32'h7777_7777;
    tick();
    dbus.data_data_ok = 1'b0;
    checkOutput("rw_stale", {31'd0, out_valid}, 32'd0);
    checkOutput("rw_wtval", out_wt_val, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage data-access unit of the pipelined MIPS core. Consumes the registered load/store request produced by the execute stage (address, read/write strobes, access type, byte enables, store operand). Drives the core's SRAM-like data port (req / addr_ok / data_ok), aligns and sign/zero-extends load data, and hands a register-writeback record to the writeback stage. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- in_valid  in  1  request from execute stage valid
- in_ready  out  1  block accepts request this cycle
- in_pc  in  32  instruction PC
- in_addr  in  32  effective address
- in_read / in_write  in  1 each  load / store
- in_lw_sw_type  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
- in_byte_enable  in  4  lane enables from execute stage
- in_store_val  in  32  rt operand (store data, low-aligned)
- in_alu_val  in  32  non-load writeback value
- in_wren  in  1  register write enable
- in_wt_addr  in  5  destination register
- flush  in  1  exception flush
- data_req  out  1  data-port request
- data_wr  out  1  1 = write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  byte address
- data_wstrb  out  4  write lane strobes
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  read data
- out_valid  out  1  writeback record valid
- out_ready  in  1  writeback stage accepts record
- out_pc  out  32  PC of record
- out_wren  out  1  register write enable
- out_wt_addr  out  5  destination register
- out_wt_val  out  32  writeback value
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT, DISCARD.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept with in_read|in_write set: latch request, go to REQ. Accept with neither: load out_* from in_alu_val, out_valid=1, stay IDLE.
- REQ: data_req=1, data_* held stable from latched fields. On data_addr_ok: go to WAIT. On flush without addr_ok: drop request, go to IDLE, no output.
- WAIT: on data_data_ok, go to IDLE and register the record (out_valid=1). If flush arrives in WAIT, go to DISCARD; on data_data_ok in DISCARD, go to IDLE, no output.
- data_data_ok is ignored in IDLE and REQ. A response is never sampled in the same cycle as its addr_ok.
- Store data: SB replicates byte ×4. SH replicates halfword ×2. SW passes through. data_wstrb = in_byte_enable for stores, 0 for loads.
- data_size from type: byte types → 0, half → 1, word → 2.
- Load data: rdata shifted right by addr[1:0]*8. LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged. Stores write out_wt_val = 0 with out_wren = 0.
- Alignment is checked by the execute stage; this block performs no check.
- Output register: out_valid clears on out_ready when no new record loads the same cycle. flush clears out_valid.

## Timing
- Reset: state=IDLE; data_req, data_wr, data_wstrb, out_valid, out_wren, busy all 0. data_addr, data_wdata, data_size, out_pc, out_wt_addr, out_wt_val all 0.
- Pass-through: accepted at edge t → out_valid from t+1.
- Memory: accepted at t → data_req high from t+1. addr_ok sampled at edge a → WAIT. data_ok sampled at edge d>a → out_valid from d+1.
- Minimum load-to-use latency: 3 cycles (addr_ok on first REQ cycle, data_ok next cycle).
- Reset overrides all; a transaction in flight at reset is abandoned.

## Test plan
- ALU pass-through: in_alu_val=0x12345678, wt_addr=5, in_wren=1 → next cycle out_valid=1, out_wt_val=0x12345678, data_req never asserted.
- LB at addr 0x...03, rdata=0x80FF0000, addr_ok after 2 cycles, data_ok 3 cycles later → out_wt_val=0xFFFFFF80. Same case with LBU → 0x00000080.
- SH at addr 0x...02, store_val=0x0000ABCD, be=4'b1100 → data_wr=1, data_size=1, data_wdata=0xABCDABCD, data_wstrb=1100; out_wren=0.
- Flush in REQ before addr_ok → data_req drops next cycle, no out_valid. Flush in WAIT → DISCARD, later data_ok yields no output, then in_ready returns.
- Backpressure: out_ready=0 with out_valid=1 → in_ready=0, record held stable until out_ready=1.
- Reset asserted during WAIT → next cycle state IDLE, all outputs at reset values, stale data_ok ignored.
